// File: rtl/platform_band_ctrl.sv
// Platform band table: game-side shadow bank, vblank-aligned commit to the active bank, per-line hblank scan.
// Line result lands NUM_BANDS+2 cycles after hcount==H_ACTIVE; wr_ready drops only in the single commit cycle.
module platform_band_ctrl #(
  parameter int NUM_BANDS = 4,
  parameter int H_ACTIVE  = 640,
  parameter int H_TOTAL   = 800,
  parameter int V_ACTIVE  = 480,
  parameter int V_TOTAL   = 525,
  localparam int IDX_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       hcount,
  input  logic [9:0]       vcount,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [9:0]       wr_start,
  input  logic [9:0]       wr_end,
  input  logic [2:0]       wr_color,
  input  logic             commit_req,
  output logic             commit_pending,
  output logic             commit_done,
  output logic             line_hit,
  output logic [2:0]       line_color
);

  localparam logic [9:0]       HA       = 10'(H_ACTIVE);
  localparam logic [9:0]       HT       = 10'(H_TOTAL);
  localparam logic [9:0]       VA       = 10'(V_ACTIVE);
  localparam logic [9:0]       VT       = 10'(V_TOTAL);
  localparam logic [9:0]       VT_LAST  = 10'(V_TOTAL - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

  typedef struct packed {
    logic [9:0] start;
    logic [9:0] stop;
    logic [2:0] color;
  } band_t;

  typedef enum logic [1:0] {IDLE, SCAN, LATCH, COMMIT} state_t;

  state_t           state_q, state_d;
  band_t            sh_q [NUM_BANDS];
  band_t            sh_d [NUM_BANDS];
  band_t            ac_q [NUM_BANDS];
  band_t            ac_d [NUM_BANDS];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [9:0]       nv_q, nv_d;
  logic             found_q, found_d;
  logic [2:0]       col_q, col_d;
  logic             line_hit_q, line_hit_d;
  logic [2:0]       line_color_q, line_color_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;

  band_t cur_band;
  logic  band_match;

  assign cur_band   = ac_q[idx_q];
  assign band_match = (cur_band.start < cur_band.stop) &&
                      (cur_band.start <= nv_q) && (nv_q < cur_band.stop);

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    ac_d         = ac_q;
    idx_d        = idx_q;
    nv_d         = nv_q;
    found_d      = found_q;
    col_d        = col_q;
    line_hit_d   = line_hit_q;
    line_color_d = line_color_q;
    pending_d    = pending_q | commit_req;
    done_d       = 1'b0;

    if (wr_valid && (state_q != COMMIT)) begin
      sh_d[wr_idx] = '{start: wr_start, stop: wr_end, color: wr_color};
    end

    case (state_q)
      IDLE: begin
        if ((hcount == 10'd0) && (vcount == VA) && (pending_q || commit_req)) begin
          state_d = COMMIT;
        end else if (hcount == HA) begin
          state_d = SCAN;
          idx_d   = '0;
          found_d = 1'b0;
          col_d   = 3'd0;
          // Out-of-range timing gets a target past the visible area, so it can never hit.
          if ((hcount < HT) && (vcount < VT)) begin
            nv_d = (vcount == VT_LAST) ? 10'd0 : vcount + 10'd1;
          end else begin
            nv_d = VA;
          end
        end
      end
      SCAN: begin
        if (!found_q && band_match) begin
          found_d = 1'b1;
          col_d   = cur_band.color;
        end
        if (idx_q == LAST_IDX) begin
          state_d = LATCH;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      LATCH: begin
        line_hit_d   = found_q && (nv_q < VA);
        line_color_d = (found_q && (nv_q < VA)) ? col_q : 3'd0;
        state_d      = IDLE;
      end
      COMMIT: begin
        // No write is accepted in this cycle, so sh_q already holds every accepted write.
        ac_d      = sh_q;
        pending_d = commit_req;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sh_q         <= '{default: '0};
      ac_q         <= '{default: '0};
      idx_q        <= '0;
      nv_q         <= '0;
      found_q      <= 1'b0;
      col_q        <= 3'd0;
      line_hit_q   <= 1'b0;
      line_color_q <= 3'd0;
      pending_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      ac_q         <= ac_d;
      idx_q        <= idx_d;
      nv_q         <= nv_d;
      found_q      <= found_d;
      col_q        <= col_d;
      line_hit_q   <= line_hit_d;
      line_color_q <= line_color_d;
      pending_q    <= pending_d;
      done_q       <= done_d;
    end
  end

  assign wr_ready       = (state_q != COMMIT);
  assign commit_pending = pending_q;
  assign commit_done    = done_q;
  assign line_hit       = line_hit_q;
  assign line_color     = line_color_q;

endmodule

// File: tb/tb_platform_band_ctrl.sv
// Bench for platform_band_ctrl on a shrunken raster: table-driven band cases, hand sequences, random traffic vs a frame-level model.
module tb_platform_band_ctrl;

  localparam int NB = 4;
  localparam int HA = 12;
  localparam int HT = 20;
  localparam int VA = 24;
  localparam int VT = 28;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hcount, vcount;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_idx;
  logic [9:0] wr_start, wr_end;
  logic [2:0] wr_color;
  logic       commit_req;
  logic       commit_pending, commit_done, line_hit;
  logic [2:0] line_color;

  always #5 clk = ~clk;

  platform_band_ctrl #(
    .NUM_BANDS(NB), .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_start(wr_start), .wr_end(wr_end), .wr_color(wr_color),
    .commit_req(commit_req), .commit_pending(commit_pending), .commit_done(commit_done),
    .line_hit(line_hit), .line_color(line_color)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: band tables, commit bookkeeping, and per-line expected result.
  int m_sh_s[NB], m_sh_e[NB], m_sh_c[NB];
  int m_ac_s[NB], m_ac_e[NB], m_ac_c[NB];
  bit m_pending, m_in_commit, m_done, m_hit, m_armed;
  int m_col, m_nv;

  int hit_cnt, done_cnt, nready_cnt;
  bit seen_done;

  typedef struct {
    int s0, e0, c0, s1, e1, c1;
    int line, exp_hit, exp_col;
  } vec_t;
  vec_t tbl[17];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (v=%0d h=%0d)", name, act, exp, vcount, hcount);
    end
  endtask

  function automatic int lookup(int nv);
    if (nv >= VA) return -1;
    for (int i = 0; i < NB; i++)
      if (m_ac_s[i] < m_ac_e[i] && m_ac_s[i] <= nv && nv < m_ac_e[i]) return m_ac_c[i];
    return -1;
  endfunction

  task automatic model_step();
    bit commit_now, cp;
    int c;
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        m_sh_s[i] = 0; m_sh_e[i] = 0; m_sh_c[i] = 0;
        m_ac_s[i] = 0; m_ac_e[i] = 0; m_ac_c[i] = 0;
      end
      m_pending = 0; m_in_commit = 0; m_done = 0; m_hit = 0; m_col = 0; m_armed = 0;
      return;
    end
    commit_now = m_in_commit;
    cp = (hcount == 0) && (vcount == VA) && (m_pending || commit_req);
    m_done = commit_now;
    if (commit_now)
      for (int i = 0; i < NB; i++) begin
        m_ac_s[i] = m_sh_s[i]; m_ac_e[i] = m_sh_e[i]; m_ac_c[i] = m_sh_c[i];
      end
    if (wr_valid && !commit_now) begin
      m_sh_s[wr_idx] = int'(wr_start);
      m_sh_e[wr_idx] = int'(wr_end);
      m_sh_c[wr_idx] = int'(wr_color);
    end
    m_pending   = commit_now ? commit_req : (m_pending || commit_req);
    m_in_commit = cp;
    if (hcount == HA + NB + 1 && m_armed) begin
      c = lookup(m_nv);
      m_hit = (c >= 0);
      m_col = (c < 0) ? 0 : c;
      m_armed = 0;
    end
    if (hcount == HA) begin
      m_armed = 1;
      m_nv = (vcount == VT - 1) ? 0 : int'(vcount) + 1;
    end
  endtask

  // One pixel: compare this cycle's outputs, clock, advance the raster.
  task automatic cycle();
    logic [6:0] act, exp;
    act = {wr_ready, commit_pending, commit_done, line_hit, line_color};
    exp = {!m_in_commit, m_pending, m_done, m_hit, 3'(m_col)};
    check("outs", int'(act), int'(exp));
    if (line_hit) hit_cnt++;
    if (commit_done) begin done_cnt++; seen_done = 1; end
    if (!wr_ready) nready_cnt++;
    @(posedge clk);
    model_step();
    #1;
    if (hcount == HT - 1) begin
      hcount = 10'd0;
      vcount = (vcount == VT - 1) ? 10'd0 : 10'(vcount + 10'd1);
    end else begin
      hcount = 10'(hcount + 10'd1);
    end
  endtask

  task automatic run_to(int v, int h);
    int n = 0;
    while (!(vcount == v && hcount == h) && n < 2 * FR) begin
      cycle();
      n++;
    end
    check("run_to_reach", int'(vcount == v && hcount == h), 1);
  endtask

  task automatic wr(int idx, int s, int e, int c);
    bit acc;
    int n = 0;
    wr_valid = 1; wr_idx = 2'(idx); wr_start = 10'(s); wr_end = 10'(e); wr_color = 3'(c);
    do begin
      acc = wr_ready;
      cycle();
      n++;
    end while (!acc && n < 4);
    check("wr_accept", int'(acc), 1);
    wr_valid = 0;
  endtask

  task automatic commit();
    int n = 0;
    seen_done = 0;
    commit_req = 1;
    cycle();
    commit_req = 0;
    while (!seen_done && n < 2 * FR) begin
      cycle();
      n++;
    end
    check("commit_done_seen", int'(seen_done), 1);
  endtask

  initial begin
    tbl[0]  = '{10, 14, 4,  0,  0, 0,  9, 0, 0};
    tbl[1]  = '{10, 14, 4,  0,  0, 0, 10, 1, 4};
    tbl[2]  = '{10, 14, 4,  0,  0, 0, 13, 1, 4};
    tbl[3]  = '{10, 14, 4,  0,  0, 0, 14, 0, 0};
    tbl[4]  = '{13, 15, 1, 12, 16, 2, 12, 1, 2};
    tbl[5]  = '{13, 15, 1, 12, 16, 2, 13, 1, 1};
    tbl[6]  = '{13, 15, 1, 12, 16, 2, 14, 1, 1};
    tbl[7]  = '{13, 15, 1, 12, 16, 2, 15, 1, 2};
    tbl[8]  = '{13, 15, 1, 12, 16, 2, 16, 0, 0};
    tbl[9]  = '{20, 20, 5, 25,  3, 6, 20, 0, 0};
    tbl[10] = '{20, 20, 5, 25,  3, 6,  2, 0, 0};
    tbl[11] = '{ 0,  5, 3,  0,  0, 0,  0, 1, 3};
    tbl[12] = '{ 0,  5, 3,  0,  0, 0,  4, 1, 3};
    tbl[13] = '{ 0,  5, 3,  0,  0, 0,  5, 0, 0};
    tbl[14] = '{22, 27, 7,  0,  0, 0, 23, 1, 7};
    tbl[15] = '{22, 27, 7,  0,  0, 0, 24, 0, 0};
    tbl[16] = '{22, 27, 7,  0,  0, 0, 26, 0, 0};

    reset = 1; hcount = 0; vcount = 0; wr_valid = 0; wr_idx = 0;
    wr_start = 0; wr_end = 0; wr_color = 0; commit_req = 0;
    for (int i = 0; i < NB; i++) begin
      m_sh_s[i] = 0; m_sh_e[i] = 0; m_sh_c[i] = 0;
      m_ac_s[i] = 0; m_ac_e[i] = 0; m_ac_c[i] = 0;
    end
    m_pending = 0; m_in_commit = 0; m_done = 0; m_hit = 0; m_col = 0; m_armed = 0; m_nv = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_line_hit", int'(line_hit), 0);
    check("rst_line_color", int'(line_color), 0);
    check("rst_pending", int'(commit_pending), 0);
    check("rst_done", int'(commit_done), 0);
    check("rst_wr_ready", int'(wr_ready), 1);
    reset = 0;

    // Empty frame: nothing hits, no commit, never stalled.
    hit_cnt = 0; done_cnt = 0; nready_cnt = 0;
    repeat (FR) cycle();
    check("empty_hits", hit_cnt, 0);
    check("empty_done", done_cnt, 0);
    check("empty_stall", nready_cnt, 0);

    for (int k = 0; k < 17; k++) begin
      if (k == 0 || tbl[k].s0 != tbl[k-1].s0 || tbl[k].e0 != tbl[k-1].e0 ||
          tbl[k].c0 != tbl[k-1].c0 || tbl[k].s1 != tbl[k-1].s1 ||
          tbl[k].e1 != tbl[k-1].e1 || tbl[k].c1 != tbl[k-1].c1) begin
        wr(0, tbl[k].s0, tbl[k].e0, tbl[k].c0);
        wr(1, tbl[k].s1, tbl[k].e1, tbl[k].c1);
        wr(2, 0, 0, 0);
        wr(3, 0, 0, 0);
        done_cnt = 0;
        commit();
        check("tbl_single_done", done_cnt, 1);
      end
      run_to(tbl[k].line, 2);
      check("tbl_hit", int'(line_hit), tbl[k].exp_hit);
      check("tbl_color", int'(line_color), tbl[k].exp_col);
    end

    // Shadow rewrite without commit must not disturb the displayed bands.
    wr(0, 10, 14, 4);
    commit();
    run_to(11, 2);
    check("notear_before", int'({line_hit, line_color}), 4'b1100);
    wr(0, 20, 22, 1);
    run_to(21, 2);
    check("notear_new_absent", int'(line_hit), 0);
    run_to(11, 2);
    check("notear_old_kept", int'({line_hit, line_color}), 4'b1100);
    commit_req = 1;
    cycle();
    commit_req = 0;
    check("pending_set", int'(commit_pending), 1);
    run_to(11, 2);
    check("notear_old_gone", int'(line_hit), 0);
    run_to(21, 2);
    check("notear_new_shown", int'({line_hit, line_color}), 4'b1001);

    // Write held through the commit cycle: stalled once, lands in shadow only.
    commit_req = 1;
    cycle();
    commit_req = 0;
    run_to(VA, 1);
    check("commit_cycle_rdy", int'(wr_ready), 0);
    wr_valid = 1; wr_idx = 2; wr_start = 1; wr_end = 3; wr_color = 5;
    cycle();
    check("post_commit_rdy", int'(wr_ready), 1);
    check("post_commit_done", int'(commit_done), 1);
    check("post_commit_pending", int'(commit_pending), 0);
    cycle();
    wr_valid = 0;
    cycle();
    check("done_one_cycle", int'(commit_done), 0);
    run_to(1, 2);
    check("held_write_absent", int'(line_hit), 0);
    commit();
    run_to(1, 2);
    check("held_write_committed", int'({line_hit, line_color}), 4'b1101);

    // Reset while a scan is in flight and a commit is pending.
    commit_req = 1;
    cycle();
    commit_req = 0;
    run_to(1, HA + 2);
    check("prereset_pending", int'(commit_pending), 1);
    check("prereset_hit", int'(line_hit), 1);
    reset = 1;
    cycle();
    reset = 0;
    check("midscan_rst_hit", int'(line_hit), 0);
    check("midscan_rst_color", int'(line_color), 0);
    check("midscan_rst_pending", int'(commit_pending), 0);
    check("midscan_rst_ready", int'(wr_ready), 1);
    done_cnt = 0;
    run_to(VA, 8);
    check("discarded_commit", done_cnt, 0);

    // Random traffic against the model.
    for (int k = 0; k < 3 * FR; k++) begin
      wr_valid   = ($urandom_range(15) == 0);
      wr_idx     = 2'($urandom_range(NB - 1));
      wr_start   = 10'($urandom_range(31));
      wr_end     = 10'($urandom_range(31));
      wr_color   = 3'($urandom_range(7));
      commit_req = ($urandom_range(119) == 0);
      cycle();
    end
    wr_valid = 0; commit_req = 0;
    repeat (FR) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
